// File: rtl/spi_flash_reader_if.sv
// Byte-level SPI shifter handshake between spi_flash_reader and the shifter.
//   spi_cs_n     flash chip select, active low (driven by the reader)
//   spi_start    byte start request (driven by the reader)
//   spi_data_tx  byte to shift out (driven by the reader)
//   spi_data_rx  byte shifted in (driven by the shifter)
//   spi_busy     shifter busy flag (driven by the shifter)
// master = reader side, slave = shifter side.
interface spi_flash_reader_if;
  logic       spi_cs_n;
  logic       spi_start;
  logic [7:0] spi_data_tx;
  logic [7:0] spi_data_rx;
  logic       spi_busy;

  modport master (
    output spi_cs_n, spi_start, spi_data_tx,
    input  spi_data_rx, spi_busy
  );

  modport slave (
    input  spi_cs_n, spi_start, spi_data_tx,
    output spi_data_rx, spi_busy
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI flash block reader. Accepts a host request (addr, word_count), issues
// READ_CMD plus a 24-bit address through the shifter start/busy handshake,
// then reassembles returned bytes into big-endian 16-bit words offered on a
// valid/ready port.
//   raw_clk, reset_n     clock, asynchronous active-low reset
//   req/addr/word_count  request, sampled in IDLE only
//   busy/done            transaction in flight / one-cycle completion pulse
//   word/word_index      assembled word and its 0-based index
//   word_valid/ready     output handshake
//   spi                  shifter handshake (master side)
module spi_flash_reader #(
  parameter logic [7:0]  READ_CMD        = 8'h03,
  parameter int unsigned CS_SETUP_CYCLES = 16,
  parameter int unsigned CS_HOLD_CYCLES  = 16
) (
  input  logic               raw_clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic [23:0]        addr,
  input  logic [15:0]        word_count,
  output logic               busy,
  output logic               done,
  output logic [15:0]        word,
  output logic [15:0]        word_index,
  output logic               word_valid,
  input  logic               word_ready,
  spi_flash_reader_if.master spi
);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADDR_HI, ADDR_MID, ADDR_LO,
    READ_HI, READ_LO, EMIT, CS_HOLD, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;   // 0: start held until busy seen, 1: wait for busy to clear
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] word_q, word_d;
  logic [15:0] idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        cs_n_q, cs_n_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d;

  logic [7:0]  byte_tx;
  state_t      byte_next;
  logic        in_byte;

  // Byte to send and successor for each byte-transfer state.
  always_comb begin
    byte_tx   = 8'h00;
    byte_next = IDLE;
    in_byte   = 1'b0;
    case (state_q)
      CMD:      begin byte_tx = READ_CMD;      byte_next = ADDR_HI;  in_byte = 1'b1; end
      ADDR_HI:  begin byte_tx = addr_q[23:16]; byte_next = ADDR_MID; in_byte = 1'b1; end
      ADDR_MID: begin byte_tx = addr_q[15:8];  byte_next = ADDR_LO;  in_byte = 1'b1; end
      ADDR_LO:  begin byte_tx = addr_q[7:0];   byte_next = READ_HI;  in_byte = 1'b1; end
      READ_HI:  begin byte_tx = 8'h00;         byte_next = READ_LO;  in_byte = 1'b1; end
      READ_LO:  begin byte_tx = 8'h00;         byte_next = EMIT;     in_byte = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    cs_n_d  = cs_n_q;
    start_d = start_q;
    tx_d    = tx_q;

    if (in_byte) begin
      tx_d = byte_tx;
      if (!phase_q) begin
        start_d = 1'b1;
        // Only a busy seen while our own start is up belongs to this byte.
        if (start_q && spi.spi_busy) begin
          start_d = 1'b0;
          phase_d = 1'b1;
        end
      end else if (!spi.spi_busy) begin
        phase_d = 1'b0;
        state_d = byte_next;
        if (state_q == READ_HI) word_d[15:8] = spi.spi_data_rx;
        if (state_q == READ_LO) begin
          word_d[7:0] = spi.spi_data_rx;
          valid_d     = 1'b1;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_d  = addr;
            count_d = word_count;
            busy_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
            phase_d = 1'b0;
            if (word_count == 16'd0) begin
              state_d = FINISH;
            end else begin
              cs_n_d  = 1'b0;
              state_d = CS_SETUP;
            end
          end
        end
        CS_SETUP: begin
          if (32'(cnt_q) + 32'd1 >= CS_SETUP_CYCLES) state_d = CMD;
          else                                       cnt_d   = cnt_q + 16'd1;
        end
        EMIT: begin
          if (valid_q && word_ready) begin
            valid_d = 1'b0;
            if (idx_q == count_q - 16'd1) begin
              cnt_d   = '0;
              state_d = CS_HOLD;
            end else begin
              idx_d   = idx_q + 16'd1;
              state_d = READ_HI;
            end
          end
        end
        CS_HOLD: begin
          if (32'(cnt_q) + 32'd1 >= CS_HOLD_CYCLES) begin
            cs_n_d  = 1'b1;
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cs_n_q  <= 1'b1;
      start_q <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      cs_n_q  <= cs_n_d;
      start_q <= start_d;
      tx_q    <= tx_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign word            = word_q;
  assign word_index      = idx_q;
  assign word_valid      = valid_q;
  assign spi.spi_cs_n    = cs_n_q;
  assign spi.spi_start   = start_q;
  assign spi.spi_data_tx = tx_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural shifter model,
// randomized consumer, and a transaction-level reference model.
module tb_spi_flash_reader;
  localparam int unsigned SETUP = 16;
  localparam int unsigned HOLD  = 16;

  logic        raw_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, word_valid;
  logic [15:0] word, word_index;
  logic        word_ready;

  spi_flash_reader_if bus();

  spi_flash_reader #(
    .READ_CMD(8'h03), .CS_SETUP_CYCLES(SETUP), .CS_HOLD_CYCLES(HOLD)
  ) dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .req(req), .addr(addr),
    .word_count(word_count), .busy(busy), .done(done), .word(word),
    .word_index(word_index), .word_valid(word_valid),
    .word_ready(word_ready), .spi(bus.master)
  );

  always #5 raw_clk = ~raw_clk;

  int unsigned cyc = 0;
  always @(posedge raw_clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference data for the current transaction.
  logic [7:0]  data_bytes[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_word[$];

  // Shifter model: busy rises busy_delay cycles after start, stays 4 cycles.
  int unsigned busy_delay = 3;
  logic [7:0]  resp_q[$];
  logic [7:0]  tx_log[$];
  initial begin
    bus.spi_busy    = 1'b0;
    bus.spi_data_rx = '0;
    forever begin
      @(posedge raw_clk);
      if (bus.spi_start === 1'b1 && bus.spi_busy === 1'b0 && reset_n === 1'b1) begin
        tx_log.push_back(bus.spi_data_tx);
        repeat (busy_delay - 1) @(posedge raw_clk);
        #1 bus.spi_busy = 1'b1;
        repeat (4) @(posedge raw_clk);
        #1;
        if (resp_q.size() > 0) bus.spi_data_rx = resp_q.pop_front();
        else                   bus.spi_data_rx = 8'($urandom);
        bus.spi_busy = 1'b0;
      end
    end
  end

  // Observer and consumer, all on the falling edge.
  logic [15:0] got_word[$];
  logic [15:0] got_idx[$];
  int unsigned pulse_lens[$];
  int unsigned ready_pct = 100;
  int          stall_idx = -1;
  int unsigned stall_left = 0;
  logic [15:0] stall_word;
  logic        stall_seen, stall_word_changed, start_in_stall;
  logic        start_cs_high_err, tx_unstable;
  int unsigned n_done = 0, n_cs_fall = 0, n_start_pulses = 0;
  int unsigned t_cs_fall, t_first_start, t_cs_rise, t_done, t_last_accept, t_req;
  int unsigned pulse_len;
  logic        first_start_seen, prev_start, prev_cs_n;
  logic [7:0]  tx_at_start;

  initial begin
    word_ready = 1'b0;
    prev_start = 1'b0; prev_cs_n = 1'b1; first_start_seen = 1'b0;
    stall_seen = 1'b0; stall_word_changed = 1'b0; start_in_stall = 1'b0;
    start_cs_high_err = 1'b0; tx_unstable = 1'b0; tx_at_start = '0;
    pulse_len = 0; stall_word = '0;
    t_cs_fall = 0; t_first_start = 0; t_cs_rise = 0; t_done = 0;
    t_last_accept = 0; t_req = 0;
    forever begin
      @(negedge raw_clk);
      if (word_valid === 1'b1 && stall_left > 0 && int'(word_index) == stall_idx) begin
        if (!stall_seen) begin stall_seen = 1'b1; stall_word = word; end
        if (word !== stall_word) stall_word_changed = 1'b1;
        if (bus.spi_start !== 1'b0) start_in_stall = 1'b1;
        stall_left--;
        word_ready = 1'b0;
      end else begin
        word_ready = ($urandom_range(99) < ready_pct);
      end
      if (word_valid === 1'b1 && word_ready) begin
        got_word.push_back(word);
        got_idx.push_back(word_index);
        t_last_accept = cyc;
      end
      if (prev_cs_n === 1'b1 && bus.spi_cs_n === 1'b0) begin
        t_cs_fall = cyc; n_cs_fall++; first_start_seen = 1'b0;
      end
      if (prev_cs_n === 1'b0 && bus.spi_cs_n === 1'b1) t_cs_rise = cyc;
      if (bus.spi_start === 1'b1) begin
        if (!prev_start) begin
          n_start_pulses++;
          pulse_len   = 0;
          tx_at_start = bus.spi_data_tx;
          if (!first_start_seen) begin first_start_seen = 1'b1; t_first_start = cyc; end
        end
        pulse_len++;
        if (bus.spi_cs_n !== 1'b0) start_cs_high_err = 1'b1;
      end else if (prev_start) begin
        pulse_lens.push_back(pulse_len);
      end
      if ((bus.spi_start === 1'b1 || bus.spi_busy === 1'b1) && bus.spi_cs_n === 1'b0 &&
          bus.spi_data_tx !== tx_at_start)
        tx_unstable = 1'b1;
      if (done === 1'b1) begin n_done++; t_done = cyc; end
      prev_start = (bus.spi_start === 1'b1);
      prev_cs_n  = (bus.spi_cs_n !== 1'b0);
    end
  end

  // Build the expected byte stream and words from the flash READ rules.
  task automatic prepare(input logic [23:0] a, input logic [15:0] c);
    logic [7:0] hi, lo;
    tx_log.delete(); got_word.delete(); got_idx.delete(); pulse_lens.delete();
    resp_q.delete(); exp_tx.delete(); exp_word.delete();
    start_cs_high_err = 1'b0; tx_unstable = 1'b0;
    stall_seen = 1'b0; stall_word_changed = 1'b0; start_in_stall = 1'b0;
    exp_tx.push_back(8'h03);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    repeat (4) resp_q.push_back(8'($urandom));
    for (int unsigned i = 0; i < 32'(c); i++) begin
      if (data_bytes.size() > 0) hi = data_bytes.pop_front(); else hi = 8'($urandom);
      if (data_bytes.size() > 0) lo = data_bytes.pop_front(); else lo = 8'($urandom);
      resp_q.push_back(hi);
      resp_q.push_back(lo);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00);
      exp_word.push_back({hi, lo});
    end
    data_bytes.delete();
  endtask

  task automatic drive_req(input logic [23:0] a, input logic [15:0] c);
    @(negedge raw_clk);
    req = 1'b1; addr = a; word_count = c; t_req = cyc;
    @(negedge raw_clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int unsigned base, input int unsigned limit, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge raw_clk);
      if (n_done > base) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge raw_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge raw_clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (word !== 16'h0) begin n_errors++; $display("FAIL reset_word: got %h want 0000", word); end
    n_checks++; if (word_index !== 16'h0) begin n_errors++; $display("FAIL reset_index: got %h want 0000", word_index); end
    n_checks++; if (word_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", word_valid); end
    n_checks++; if (bus.spi_cs_n !== 1'b1) begin n_errors++; $display("FAIL reset_cs_n: got %b want 1", bus.spi_cs_n); end
    n_checks++; if (bus.spi_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b want 0", bus.spi_start); end
    n_checks++; if (bus.spi_data_tx !== 8'h0) begin n_errors++; $display("FAIL reset_tx: got %h want 00", bus.spi_data_tx); end
    reset_n = 1'b1;
    repeat (2) @(negedge raw_clk);
  endtask

  task automatic test_basic();
    logic ok; int unsigned base; logic [7:0] a8; logic [15:0] a16;
    busy_delay = 3; ready_pct = 100;
    data_bytes.push_back(8'hAB); data_bytes.push_back(8'hCD);
    prepare(24'h012345, 16'd1);
    base = n_done;
    drive_req(24'h012345, 16'd1);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_high: got %b want 1", busy); end
    wait_done(base, 3000, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_timeout: no done within budget"); end
    n_checks++; if (tx_log.size() !== exp_tx.size()) begin n_errors++; $display("FAIL basic_tx_count: got %0d want %0d", tx_log.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      a8 = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      n_checks++; if (a8 !== exp_tx[i]) begin n_errors++; $display("FAIL basic_tx[%0d]: got %h want %h", i, a8, exp_tx[i]); end
    end
    a16 = (got_word.size() > 0) ? got_word[0] : 16'hxxxx;
    n_checks++; if (a16 !== 16'hABCD) begin n_errors++; $display("FAIL basic_word: got %h want abcd", a16); end
    a16 = (got_idx.size() > 0) ? got_idx[0] : 16'hxxxx;
    n_checks++; if (a16 !== 16'h0) begin n_errors++; $display("FAIL basic_index: got %h want 0000", a16); end
    n_checks++; if (n_done - base !== 1) begin n_errors++; $display("FAIL basic_done_count: got %0d want 1", n_done - base); end
    n_checks++; if (t_first_start - t_cs_fall !== SETUP + 1) begin n_errors++; $display("FAIL basic_setup: got %0d want %0d", t_first_start - t_cs_fall, SETUP + 1); end
    n_checks++; if (t_cs_rise - t_last_accept !== HOLD + 1) begin n_errors++; $display("FAIL basic_hold: got %0d want %0d", t_cs_rise - t_last_accept, HOLD + 1); end
    n_checks++; if (t_done - t_cs_rise !== 1) begin n_errors++; $display("FAIL basic_done_after_cs: got %0d want 1", t_done - t_cs_rise); end
    n_checks++; if (t_cs_fall - t_req !== 1) begin n_errors++; $display("FAIL basic_req_to_cs: got %0d want 1", t_cs_fall - t_req); end
    n_checks++; if (start_cs_high_err !== 1'b0) begin n_errors++; $display("FAIL basic_start_cs_high: got %b want 0", start_cs_high_err); end
    n_checks++; if (tx_unstable !== 1'b0) begin n_errors++; $display("FAIL basic_tx_stable: got %b want 0", tx_unstable); end
    n_checks++; if (bus.spi_cs_n !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL basic_idle_after: cs_n=%b busy=%b want 1/0", bus.spi_cs_n, busy); end
  endtask

  task automatic test_backpressure();
    logic ok; int unsigned base; logic [7:0] a8; logic [15:0] a16, i16;
    busy_delay = 3; ready_pct = 100;
    for (int unsigned b = 1; b <= 6; b++) data_bytes.push_back(8'(b * 8'h11));
    prepare(24'hA0B0C0, 16'd3);
    stall_idx = 1; stall_left = 10;
    base = n_done;
    drive_req(24'hA0B0C0, 16'd3);
    wait_done(base, 3000, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_timeout: no done within budget"); end
    n_checks++; if (tx_log.size() !== exp_tx.size()) begin n_errors++; $display("FAIL bp_tx_count: got %0d want %0d", tx_log.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      a8 = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      n_checks++; if (a8 !== exp_tx[i]) begin n_errors++; $display("FAIL bp_tx[%0d]: got %h want %h", i, a8, exp_tx[i]); end
    end
    for (int i = 0; i < exp_word.size(); i++) begin
      a16 = (i < got_word.size()) ? got_word[i] : 16'hxxxx;
      i16 = (i < got_idx.size()) ? got_idx[i] : 16'hxxxx;
      n_checks++; if (a16 !== exp_word[i] || i16 !== 16'(i)) begin n_errors++; $display("FAIL bp_word[%0d]: got %h@%0d want %h@%0d", i, a16, i16, exp_word[i], i); end
    end
    n_checks++; if (stall_left !== 0 || stall_word !== 16'h3344) begin n_errors++; $display("FAIL bp_stall_seen: left=%0d word=%h want 0/3344", stall_left, stall_word); end
    n_checks++; if (stall_word_changed !== 1'b0) begin n_errors++; $display("FAIL bp_word_stable: got %b want 0", stall_word_changed); end
    n_checks++; if (start_in_stall !== 1'b0) begin n_errors++; $display("FAIL bp_start_in_stall: got %b want 0", start_in_stall); end
    n_checks++; if (n_done - base !== 1) begin n_errors++; $display("FAIL bp_done_count: got %0d want 1", n_done - base); end
    stall_idx = -1; stall_left = 0;
  endtask

  task automatic test_zero_count();
    logic ok; int unsigned base, cs0, st0;
    prepare(24'h00FFEE, 16'd0);
    base = n_done; cs0 = n_cs_fall; st0 = n_start_pulses;
    drive_req(24'h00FFEE, 16'd0);
    wait_done(base, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL zero_timeout: no done within budget"); end
    n_checks++; if (t_done - t_req !== 2) begin n_errors++; $display("FAIL zero_latency: got %0d want 2", t_done - t_req); end
    n_checks++; if (n_cs_fall !== cs0) begin n_errors++; $display("FAIL zero_cs_fell: got %0d falls want 0", n_cs_fall - cs0); end
    n_checks++; if (n_start_pulses !== st0) begin n_errors++; $display("FAIL zero_start: got %0d starts want 0", n_start_pulses - st0); end
    n_checks++; if (n_done - base !== 1) begin n_errors++; $display("FAIL zero_done_count: got %0d want 1", n_done - base); end
  endtask

  task automatic test_slow_busy();
    logic ok; int unsigned base, st0; logic [15:0] a16;
    busy_delay = 7; ready_pct = 100;
    prepare(24'h7E5A3C, 16'd1);
    base = n_done; st0 = n_start_pulses;
    drive_req(24'h7E5A3C, 16'd1);
    wait_done(base, 3000, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL slow_timeout: no done within budget"); end
    n_checks++; if (n_start_pulses - st0 !== 6 || tx_log.size() !== 6) begin n_errors++; $display("FAIL slow_bytes: starts=%0d bytes=%0d want 6/6", n_start_pulses - st0, tx_log.size()); end
    for (int i = 0; i < pulse_lens.size(); i++) begin
      n_checks++; if (pulse_lens[i] !== busy_delay + 1) begin n_errors++; $display("FAIL slow_pulse[%0d]: got %0d want %0d", i, pulse_lens[i], busy_delay + 1); end
    end
    a16 = (got_word.size() > 0) ? got_word[0] : 16'hxxxx;
    n_checks++; if (a16 !== exp_word[0]) begin n_errors++; $display("FAIL slow_word: got %h want %h", a16, exp_word[0]); end
    busy_delay = 3;
  endtask

  task automatic test_reset_mid();
    logic ok; int unsigned base, st0; logic [15:0] a16;
    busy_delay = 3; ready_pct = 100;
    prepare(24'h112233, 16'd2);
    base = n_done; st0 = n_start_pulses;
    drive_req(24'h112233, 16'd2);
    ok = 1'b0;
    for (int unsigned i = 0; i < 1000; i++) begin
      @(negedge raw_clk);
      if (n_start_pulses - st0 >= 6) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rmid_reach_read_lo: sixth start never seen"); end
    @(negedge raw_clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.spi_cs_n !== 1'b1 || word_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rmid_immediate: cs_n=%b valid=%b busy=%b want 1/0/0", bus.spi_cs_n, word_valid, busy); end
    repeat (3) @(negedge raw_clk);
    reset_n = 1'b1;
    repeat (20) @(negedge raw_clk);
    n_checks++; if (n_done !== base) begin n_errors++; $display("FAIL rmid_no_done: got %0d dones want 0", n_done - base); end
    n_checks++; if (got_word.size() !== 0) begin n_errors++; $display("FAIL rmid_no_word: got %0d words want 0", got_word.size()); end
    prepare(24'h445566, 16'd1);
    base = n_done;
    drive_req(24'h445566, 16'd1);
    wait_done(base, 3000, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rmid_after_timeout: no done within budget"); end
    a16 = (got_word.size() > 0) ? got_word[0] : 16'hxxxx;
    n_checks++; if (a16 !== exp_word[0]) begin n_errors++; $display("FAIL rmid_after_word: got %h want %h", a16, exp_word[0]); end
    n_checks++; if (tx_log.size() !== 6 || tx_log[3] !== 8'h66) begin n_errors++; $display("FAIL rmid_after_tx: bytes=%0d want 6 ending addr 66", tx_log.size()); end
  endtask

  task automatic test_req_while_busy();
    logic ok; int unsigned base, cs0, st0; logic [7:0] a8; logic [15:0] a16;
    busy_delay = 2; ready_pct = 100;
    prepare(24'h9ABCDE, 16'd2);
    base = n_done; cs0 = n_cs_fall; st0 = n_start_pulses;
    drive_req(24'h9ABCDE, 16'd2);
    for (int unsigned i = 0; i < 1000 && n_start_pulses - st0 < 3; i++) @(negedge raw_clk);
    drive_req(24'h135790, 16'd5);
    wait_done(base, 3000, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL rwb_timeout: no done within budget"); end
    n_checks++; if (tx_log.size() !== exp_tx.size()) begin n_errors++; $display("FAIL rwb_tx_count: got %0d want %0d", tx_log.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      a8 = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      n_checks++; if (a8 !== exp_tx[i]) begin n_errors++; $display("FAIL rwb_tx[%0d]: got %h want %h", i, a8, exp_tx[i]); end
    end
    n_checks++; if (got_word.size() !== 2) begin n_errors++; $display("FAIL rwb_nwords: got %0d want 2", got_word.size()); end
    for (int i = 0; i < exp_word.size(); i++) begin
      a16 = (i < got_word.size()) ? got_word[i] : 16'hxxxx;
      n_checks++; if (a16 !== exp_word[i]) begin n_errors++; $display("FAIL rwb_word[%0d]: got %h want %h", i, a16, exp_word[i]); end
    end
    repeat (40) @(negedge raw_clk);
    n_checks++; if (n_cs_fall - cs0 !== 1 || n_done - base !== 1) begin n_errors++; $display("FAIL rwb_single_txn: cs_falls=%0d dones=%0d want 1/1", n_cs_fall - cs0, n_done - base); end
  endtask

  task automatic test_random();
    logic ok; int unsigned base; logic [23:0] a; logic [15:0] c; logic [7:0] a8; logic [15:0] a16, i16;
    for (int unsigned it = 0; it < 6; it++) begin
      busy_delay = $urandom_range(5, 1);
      ready_pct  = $urandom_range(100, 30);
      a = 24'($urandom);
      c = 16'($urandom_range(4, 1));
      prepare(a, c);
      base = n_done;
      drive_req(a, c);
      wait_done(base, 4000, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL rnd%0d_timeout: no done within budget", it); end
      n_checks++; if (tx_log.size() !== exp_tx.size()) begin n_errors++; $display("FAIL rnd%0d_tx_count: got %0d want %0d", it, tx_log.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size(); i++) begin
        a8 = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
        n_checks++; if (a8 !== exp_tx[i]) begin n_errors++; $display("FAIL rnd%0d_tx[%0d]: got %h want %h", it, i, a8, exp_tx[i]); end
      end
      n_checks++; if (got_word.size() !== exp_word.size()) begin n_errors++; $display("FAIL rnd%0d_nwords: got %0d want %0d", it, got_word.size(), exp_word.size()); end
      for (int i = 0; i < exp_word.size(); i++) begin
        a16 = (i < got_word.size()) ? got_word[i] : 16'hxxxx;
        i16 = (i < got_idx.size()) ? got_idx[i] : 16'hxxxx;
        n_checks++; if (a16 !== exp_word[i] || i16 !== 16'(i)) begin n_errors++; $display("FAIL rnd%0d_word[%0d]: got %h@%0d want %h@%0d", it, i, a16, i16, exp_word[i], i); end
      end
      n_checks++; if (n_done - base !== 1) begin n_errors++; $display("FAIL rnd%0d_done_count: got %0d want 1", it, n_done - base); end
    end
    ready_pct = 100; busy_delay = 3;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_slow_busy();
    test_reset_mid();
    test_req_while_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
